// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for one fixed-latency single-ported memory
//
// Serializes instruction-fetch (if_*) and load/store (dm_*) transactions onto
// one memory port, one transaction outstanding at a time.
// Optional feature macro: ARB_STARVE_GUARD_EN (fetch starvation guard).
//
// Ports:
//   clock, reset_n              rising-edge clock, asynchronous active-low reset
//   if_req/if_addr              fetch request + byte address (held until if_gnt)
//   if_gnt                      fetch accepted (combinational, IDLE only)
//   if_rvalid/if_rdata          one-cycle fetch response, rdata holds last value
//   dm_req/dm_we/dm_addr/dm_wdata  load/store request (held until dm_gnt)
//   dm_gnt                      load/store accepted (combinational, IDLE only)
//   dm_rvalid/dm_rdata          one-cycle load data / store ack, rdata holds last value
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory command (word address)
//   mem_rvalid/mem_rdata        memory response, MEM_LAT cycles after mem_req
//   busy                        arbiter not in IDLE

module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    // Elaboration-time parameter sanity.
    if (MEM_LAT < 1) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end
    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              owner_dm;      // 1: transaction in flight belongs to dm port
    logic              grant_if;
    logic              grant_dm;
    logic              force_if;      // starvation guard demands fetch wins a tie
    logic              rsp_fire;      // memory response accepted this cycle
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic [ADDR_W-1:0] sel_addr;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  starve_cnt;

    assign force_if = (starve_cnt == CNT_W'(STARVE_MAX));

    // Counts dm grants taken while fetch was waiting. A dm grant at the
    // limit can only happen with if_req low (otherwise fetch would have won),
    // so saturation is a safety net rather than a reachable case.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm) begin
            if (!if_req) begin
                starve_cnt <= '0;
            end else if (!force_if) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // Next state and arbitration. Grants exist only in IDLE and are
    // suppressed while reset is asserted so every output reads 0 in reset.
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        case (state)
            IDLE: begin
                if (reset_n) begin
                    // dm is the older instruction; fetch wins only when it is
                    // alone or the guard says it has waited long enough.
                    if (if_req && (!dm_req || force_if)) begin
                        grant_if = 1'b1;
                    end else if (dm_req) begin
                        grant_dm = 1'b1;
                    end
                end
                if (grant_if || grant_dm) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign if_gnt = grant_if;
    assign dm_gnt = grant_dm;

    // A response outside WAIT is stray (e.g. from a transaction discarded
    // by reset) and is ignored.
    assign rsp_fire  = (state == WAIT) && mem_rvalid;
    assign if_rvalid = rsp_fire && !owner_dm;
    assign dm_rvalid = rsp_fire && owner_dm;

    // Response data is visible in the rvalid cycle and held afterwards.
    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign dm_rdata = dm_rvalid ? mem_rdata : dm_rdata_q;

    assign busy = (state != IDLE);

    assign sel_addr = grant_dm ? dm_addr : if_addr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command capture at grant; mem_req is a single-cycle strobe during ISSUE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_dm  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= grant_if || grant_dm;
            if (grant_if || grant_dm) begin
                owner_dm  <= grant_dm;
                mem_we    <= grant_dm && dm_we;
                mem_addr  <= sel_addr >> 2;
                mem_wdata <= grant_dm ? dm_wdata : '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (dm_rvalid) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter

module tb_mem_port_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    localparam logic [1:0] OWN_IF = 2'b01;
    localparam logic [1:0] OWN_DM = 2'b10;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              busy;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial forever #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0]        own;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } txn_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    txn_t              exp_q[$];
    rsp_t              pend_q[$];
    logic [1:0]        gnt_log[$];
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    logic              inject = 1'b0;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Scoreboard: expectation pushed when a request is accepted, compared
    // when the command and the response appear.
    initial begin
        txn_t t;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (if_gnt || dm_gnt) begin
                    check("gnt_onehot", if_gnt && dm_gnt, 1'b0);
                    check("gnt_only_idle", busy, 1'b0);
                    t.own   = {dm_gnt, if_gnt};
                    t.we    = dm_gnt ? dm_we : 1'b0;
                    t.waddr = (dm_gnt ? dm_addr : if_addr) >> 2;
                    t.wdata = dm_wdata;
                    t.rdata = mem_word(t.waddr);
                    exp_q.push_back(t);
                    gnt_log.push_back(t.own);
                end
                if (mem_req) begin
                    check("mem_req_pending", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        check("mem_we", mem_we, exp_q[0].we);
                        check("mem_addr", mem_addr, exp_q[0].waddr);
                        if (exp_q[0].we) check("mem_wdata", mem_wdata, exp_q[0].wdata);
                    end
                end
                if (if_rvalid || dm_rvalid) begin
                    check("rvalid_pending", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        t = exp_q.pop_front();
                        check("rv_owner", {dm_rvalid, if_rvalid}, t.own);
                        if (!t.we) check("rv_rdata", dm_rvalid ? dm_rdata : if_rdata, t.rdata);
                    end
                end
            end
        end
    end

    // Fixed-latency memory model.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clock);
            if (mem_req) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                r.due   = cyc + MEM_LAT;
                r.rdata = mem_word(mem_addr);
                pend_q.push_back(r);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_q[0].rdata;
                void'(pend_q.pop_front());
            end else begin
                mem_rvalid = inject;
                mem_rdata  = inject ? 32'hBAD0_0BAD : 32'h0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg(input int c);
        forever begin
            @(negedge clock);
            if (cyc >= c) break;
        end
    endtask

    task automatic wait_quiet();
        bit ok;
        ok = 1'b0;
        repeat (50) begin
            @(negedge clock);
            if (!busy && exp_q.size() == 0 && pend_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("quiet_reached", ok, 1'b1);
        step();
    endtask

    task automatic wait_gnt(input bit is_dm);
        bit got;
        got = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (is_dm ? dm_gnt : if_gnt) begin
                got = 1'b1;
                break;
            end
        end
        check("gnt_seen", got, 1'b1);
        step();
        if (is_dm) dm_req = 1'b0;
        else       if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [1:0] exp_order [6];
    int t0;
    int t1;

    initial begin
`ifdef ARB_STARVE_GUARD_EN
        exp_order = '{OWN_DM, OWN_DM, OWN_DM, OWN_DM, OWN_IF, OWN_DM};
`else
        exp_order = '{OWN_DM, OWN_DM, OWN_DM, OWN_DM, OWN_DM, OWN_DM};
`endif
        mem[64'h4] = 32'h0000_0013;

        // Reset state, with a request pending to confirm gnt stays low.
        if_req = 1'b1;
        step();
        step();
        @(negedge clock);
        check("rst_ctrl", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, busy}, 7'b0);
        check("rst_data", {mem_addr, mem_wdata, if_rdata, dm_rdata}, 160'b0);
        step();
        if_req  = 1'b0;
        reset_n = 1'b1;
        step();

        // Single fetch timing.
        if_req  = 1'b1;
        if_addr = 64'h10;
        t0 = cyc;
        at_neg(t0);
        check("t1_if_gnt", if_gnt, 1'b1);
        step();
        if_req = 1'b0;
        at_neg(t0 + 1);
        check("t1_mem_cmd", {mem_req, mem_addr}, {1'b1, 64'h4});
        at_neg(t0 + 3);
        check("t1_rsp", {if_rvalid, if_rdata}, {1'b1, 32'h13});
        at_neg(t0 + 4);
        check("t1_busy_low", busy, 1'b0);
        wait_quiet();

        // Simultaneous requests: dm first, fetch at the first IDLE after.
        if_req  = 1'b1;
        if_addr = 64'h30;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 64'h20;
        t0 = cyc;
        at_neg(t0);
        check("t2_first_gnt", {dm_gnt, if_gnt}, OWN_DM);
        step();
        dm_req = 1'b0;
        at_neg(t0 + 1);
        check("t2_mem_cmd", {mem_req, mem_we, mem_addr}, {2'b10, 64'h8});
        at_neg(t0 + 3);
        check("t2_dm_rsp", {dm_rvalid, if_gnt}, 2'b10);
        at_neg(t0 + 4);
        check("t2_if_gnt", if_gnt, 1'b1);
        step();
        if_req = 1'b0;
        wait_quiet();

        // Store, then fetch the same word back through the scoreboard.
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 64'h40;
        dm_wdata = 32'hDEAD_BEEF;
        t0 = cyc;
        at_neg(t0);
        check("t3_dm_gnt", dm_gnt, 1'b1);
        step();
        dm_req = 1'b0;
        at_neg(t0 + 1);
        check("t3_mem_cmd", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 64'h10, 32'hDEAD_BEEF});
        at_neg(t0 + 3);
        check("t3_ack", {dm_rvalid, if_rvalid}, 2'b10);
        wait_quiet();
        dm_we   = 1'b0;
        if_req  = 1'b1;
        if_addr = 64'h40;
        wait_gnt(1'b0);
        wait_quiet();

        // Both requests held: grant order shows the starvation guard.
        gnt_log.delete();
        if_req  = 1'b1;
        if_addr = 64'h100;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 64'h200;
        repeat (60) begin
            @(negedge clock);
            if (gnt_log.size() >= 6) break;
        end
        step();
        if_req = 1'b0;
        dm_req = 1'b0;
        check("t4_grant_count", gnt_log.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i < gnt_log.size()) check($sformatf("t4_order%0d", i), gnt_log[i], exp_order[i]);
        end
        wait_quiet();

        // Reset in WAIT, released before the late response.
        if_req  = 1'b1;
        if_addr = 64'h80;
        t0 = cyc;
        at_neg(t0);
        check("t5_if_gnt", if_gnt, 1'b1);
        step();
        if_req = 1'b0;
        at_neg(t0 + 2);
        check("t5_in_wait", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_ctrl", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, busy}, 7'b0);
        check("t5_rst_data", {mem_addr, mem_wdata, if_rdata, dm_rdata}, 160'b0);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        at_neg(t0 + 3);
        check("t5_late_rsp_seen", mem_rvalid, 1'b1);
        check("t5_late_rsp_ignored", {if_rvalid, dm_rvalid, busy, if_rdata}, 35'b0);
        step();
        if_req  = 1'b1;
        if_addr = 64'h10;
        t1 = cyc;
        at_neg(t1);
        check("t5_regrant", if_gnt, 1'b1);
        step();
        if_req = 1'b0;
        at_neg(t1 + 3);
        check("t5_rsp", {if_rvalid, if_rdata}, {1'b1, 32'h13});
        wait_quiet();

        // Stray response while IDLE.
        inject = 1'b1;
        t0 = cyc;
        at_neg(t0);
        check("t6_stray_seen", mem_rvalid, 1'b1);
        check("t6_stray_ignored", {if_rvalid, dm_rvalid, busy}, 3'b0);
        step();
        inject = 1'b0;
        at_neg(t0 + 1);
        check("t6_still_idle", {busy, mem_req}, 2'b0);
        wait_quiet();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
